// File: rtl/aspiradora_sensor_cond.sv
// Input conditioning for the vacuum-cleaner FSM: 2-flop sync, debounce, on-pulse and hold stretching.
// Optional macro ASPIRADORA_BUMPER_PRIORITY_EN masks cleaning while evading is high.

module aspiradora_debounce #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter logic        RST_VAL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic deb_o
);
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state for the debounce counter and debounced level
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            deb_d = sync2_q;
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser and debounce state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= RST_VAL;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module aspiradora_hold_fsm #(
    parameter int unsigned HOLD = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic deb_i,
    output logic out_o
);
    localparam int unsigned HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD_S = 2'd2
    } state_e;

    state_e        state_q;
    logic [HW-1:0] cnt_q;
    logic          out_q;

    // Hold FSM; out_q always tracks the state being entered so the output is registered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= {HW{1'b0}};
            out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (deb_i) begin
                        state_q <= ACTIVE;
                        out_q   <= 1'b1;
                    end else begin
                        out_q   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    out_q <= 1'b1;
                    if (!deb_i) begin
                        state_q <= HOLD_S;
                        cnt_q   <= HW'(HOLD - 1);
                    end else begin
                        state_q <= ACTIVE;
                    end
                end
                HOLD_S: begin
                    if (deb_i) begin
                        state_q <= ACTIVE;
                        out_q   <= 1'b1;
                    end else if (cnt_q == {HW{1'b0}}) begin
                        state_q <= IDLE;
                        out_q   <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - HW'(1);
                        out_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= {HW{1'b0}};
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

    assign out_o = out_q;
endmodule

module aspiradora_sensor_cond #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CLEAN_HOLD = 16,
    parameter int unsigned EVADE_HOLD = 8
) (
    input  logic clk,
    input  logic power_off,
    input  logic raw_on_btn,
    input  logic raw_dirt,
    input  logic raw_bumper,
    output logic on,
    output logic cleaning,
    output logic evading
);
    logic deb_btn_s, deb_dirt_s, deb_bumper_s;
    logic btn_prev_q, on_q;
    logic cleaning_fsm_s, evading_s;

    // Button debouncer resets high so a press held through reset gives no pulse
    aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_btn (
        .clk_i(clk), .rst_i(power_off), .raw_i(raw_on_btn), .deb_o(deb_btn_s)
    );

    aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_dirt (
        .clk_i(clk), .rst_i(power_off), .raw_i(raw_dirt), .deb_o(deb_dirt_s)
    );

    aspiradora_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_bumper (
        .clk_i(clk), .rst_i(power_off), .raw_i(raw_bumper), .deb_o(deb_bumper_s)
    );

    // Rising-edge detector on the debounced button
    always_ff @(posedge clk or posedge power_off) begin
        if (power_off) begin
            btn_prev_q <= 1'b1;
            on_q       <= 1'b0;
        end else begin
            btn_prev_q <= deb_btn_s;
            on_q       <= deb_btn_s & ~btn_prev_q;
        end
    end

    aspiradora_hold_fsm #(.HOLD(CLEAN_HOLD)) u_hold_clean (
        .clk_i(clk), .rst_i(power_off), .deb_i(deb_dirt_s), .out_o(cleaning_fsm_s)
    );

    aspiradora_hold_fsm #(.HOLD(EVADE_HOLD)) u_hold_evade (
        .clk_i(clk), .rst_i(power_off), .deb_i(deb_bumper_s), .out_o(evading_s)
    );

    assign on      = on_q;
    assign evading = evading_s;
`ifdef ASPIRADORA_BUMPER_PRIORITY_EN
    // Dirt FSM keeps running underneath, so cleaning resumes if its hold outlives evading
    assign cleaning = cleaning_fsm_s & ~evading_s;
`else
    assign cleaning = cleaning_fsm_s;
`endif
endmodule

// File: tb/tb_aspiradora_sensor_cond.sv
// Directed bench for aspiradora_sensor_cond at default parameters (DEB 4, CLEAN 16, EVADE 8).
module tb_aspiradora_sensor_cond;
    logic clk = 1'b0;
    logic power_off = 1'b0;
    logic raw_on_btn = 1'b0;
    logic raw_dirt = 1'b0;
    logic raw_bumper = 1'b0;
    logic on_s, cleaning_s, evading_s;

    int n_vec = 0;
    int n_err = 0;

    aspiradora_sensor_cond dut (
        .clk(clk), .power_off(power_off), .raw_on_btn(raw_on_btn),
        .raw_dirt(raw_dirt), .raw_bumper(raw_bumper),
        .on(on_s), .cleaning(cleaning_s), .evading(evading_s)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int cnt, first, last, second, both;

    initial begin
        // asynchronous reset with all raw inputs asserted
        power_off  = 1'b1;
        raw_on_btn = 1'b1;
        raw_dirt   = 1'b1;
        raw_bumper = 1'b1;
        #3;
        check_eq("rst_async_on", on_s, 0);
        check_eq("rst_async_clean", cleaning_s, 0);
        check_eq("rst_async_evade", evading_s, 0);
        repeat (3) tick();
        check_eq("rst_on", on_s, 0);
        check_eq("rst_clean", cleaning_s, 0);
        check_eq("rst_evade", evading_s, 0);

        // release with button held: no pulse allowed
        raw_dirt   = 1'b0;
        raw_bumper = 1'b0;
        power_off  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (on_s) cnt++;
        end
        check_eq("held_btn_no_pulse", cnt, 0);
        raw_on_btn = 1'b0;
        repeat (12) tick();

        // two presses: 10 high, 10 low, 10 high
        raw_on_btn = 1'b1;
        cnt = 0; first = -1; second = -1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (on_s) begin
                cnt++;
                if (first < 0) first = i; else second = i;
            end
            if (i == 10) raw_on_btn = 1'b0;
            if (i == 20) raw_on_btn = 1'b1;
            if (i == 30) raw_on_btn = 1'b0;
        end
        check_eq("btn_pulse_count", cnt, 2);
        check_eq("btn_pulse1_lat", first, 7);
        check_eq("btn_pulse2_lat", second, 27);

        // 3-cycle bumper glitch must be rejected
        raw_bumper = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (evading_s) cnt++;
            if (i == 3) raw_bumper = 1'b0;
        end
        check_eq("glitch_reject", cnt, 0);

        // 5-cycle bumper pulse accepted: 5 + 8 cycles of evading
        raw_bumper = 1'b1;
        cnt = 0; first = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (evading_s) begin
                cnt++;
                if (first < 0) first = i;
            end
            if (i == 5) raw_bumper = 1'b0;
        end
        check_eq("bump5_lat", first, 7);
        check_eq("bump5_len", cnt, 13);

        // dirt high 20 cycles: cleaning 20 + 16 = 36 contiguous cycles
        raw_dirt = 1'b1;
        cnt = 0; first = -1; last = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (cleaning_s) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (i == 20) raw_dirt = 1'b0;
        end
        check_eq("dirt_lat", first, 7);
        check_eq("dirt_len", cnt, 36);
        check_eq("dirt_last", last, 42);

        // retrigger: high 10, low 4, high 10 -> evading 24 + 8 contiguous
        raw_bumper = 1'b1;
        cnt = 0; first = -1; last = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (evading_s) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (i == 10) raw_bumper = 1'b0;
            if (i == 14) raw_bumper = 1'b1;
            if (i == 24) raw_bumper = 1'b0;
        end
        check_eq("retrig_first", first, 7);
        check_eq("retrig_last", last, 38);
        check_eq("retrig_len", cnt, 32);

        // simultaneous dirt and bumper for 12 cycles
        raw_dirt   = 1'b1;
        raw_bumper = 1'b1;
        cnt = 0; last = 0; both = 0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (cleaning_s) cnt++;
            if (evading_s) last++;
            if (cleaning_s && evading_s) both++;
            if (i == 12) begin
                raw_dirt   = 1'b0;
                raw_bumper = 1'b0;
            end
        end
        check_eq("prio_evade_len", last, 20);
`ifdef ASPIRADORA_BUMPER_PRIORITY_EN
        check_eq("prio_clean_len", cnt, 8);
        check_eq("prio_overlap", both, 0);
`else
        check_eq("prio_clean_len", cnt, 28);
        check_eq("prio_overlap", both, 20);
`endif

        // reset in the middle of a cleaning hold
        raw_dirt = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 5) raw_dirt = 1'b0;
        end
        check_eq("midhold_pre", cleaning_s, 1);
        #2;
        power_off = 1'b1;
        #1;
        check_eq("midhold_async_drop", cleaning_s, 0);
        repeat (2) tick();
        power_off = 1'b0;
        cnt = 0;
        first = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (cleaning_s) cnt++;
            if (on_s) first++;
        end
        check_eq("midhold_no_residual", cnt, 0);
        check_eq("midhold_no_on", first, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aspiradora_sensor_cond.md
Name: aspiradora_sensor_cond

Overview:
- Input-conditioning stage directly upstream of the vacuum-cleaner control FSM.
- Takes the raw, asynchronous power button, dirt sensor and bumper sensor.
- Produces clean, synchronised, debounced control inputs for the FSM: a one-cycle on pulse, plus cleaning and evading levels with minimum hold times.
- Prevents sensor chatter from making the FSM oscillate between exploring, cleaning and evading.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised samples required before a debounced value changes (≥1).
- CLEAN_HOLD, 16: extra cycles cleaning stays high after debounced dirt falls (≥1).
- EVADE_HOLD, 8: extra cycles evading stays high after debounced bumper falls (≥1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- power_off  input  1  asynchronous, active-high reset; same net that resets the downstream FSM.
- raw_on_btn  input  1  raw power button, asynchronous to clk, active high.
- raw_dirt  input  1  raw dirt sensor, asynchronous, active high.
- raw_bumper  input  1  raw obstacle/bumper sensor, asynchronous, active high.
- on  output  1  one-cycle pulse per debounced button press.
- cleaning  output  1  conditioned dirt level.
- evading  output  1  conditioned obstacle level.

Behaviour:
- Reset: power_off high clears all registers immediately (asynchronous); it need not wait for clk.
  - on, cleaning, evading = 0.
  - Synchronisers = 0, counters = 0, both hold FSMs = IDLE.
  - Debounced button register resets to 1 ("armed-high"); all other debounced registers reset to 0.
- Synchroniser: each raw input passes through a 2-flop synchroniser (sync output = 2nd flop).
- Debounce, per channel: counter width $clog2(DEB_CYCLES+1).
  - sync == deb: counter = 0.
  - sync != deb and counter == DEB_CYCLES-1: deb <= sync, counter = 0.
  - Otherwise: counter increments.
  - Effect: a pulse shorter than DEB_CYCLES synchronised cycles is ignored.
- on: registered, on <= deb_btn & ~deb_btn_prev. Exactly 1 cycle high per debounced rising edge.
  - A button held through reset release produces no pulse; it must be released and pressed again.
- Hold FSM, one instance each for (deb_dirt → cleaning, CLEAN_HOLD) and (deb_bumper → evading, EVADE_HOLD). States IDLE, ACTIVE, HOLD:
  - IDLE: output 0; deb = 1 → ACTIVE.
  - ACTIVE: output 1; deb = 0 → HOLD with cnt = HOLD-1.
  - HOLD: output 1; deb = 1 → ACTIVE (retrigger, cnt discarded); else cnt == 0 → IDLE; else cnt--.
  - Output is registered (decoded from state register).
- Latency: raw edge to output edge = 2 + DEB_CYCLES + 1 cycles (7 at defaults) for on, cleaning and evading.
- Hold length: cleaning stays high for (debounced high time + CLEAN_HOLD) cycles; evading likewise with EVADE_HOLD.
- Channels are independent. Simultaneous dirt and bumper assert both outputs; arbitration is left to the FSM unless the optional feature is enabled.
- Reset mid-hold: outputs drop in the same instant as power_off; no residual hold after release.
- Counter widths: $clog2(max+1) of the corresponding parameter; no wrap is possible by construction.

Optional Feature:
- Macro: ASPIRADORA_BUMPER_PRIORITY_EN.
- Defined: cleaning output is gated, cleaning = cleaning_fsm & ~evading (combinational AND of registered signals).
  - Obstacle avoidance therefore always wins over dirt.
  - The dirt hold FSM keeps running internally, so cleaning reappears when evading falls if its hold has not expired.
- Undefined: cleaning and evading are fully independent.

Test Plan:
- Reset: power_off=1 with all raw inputs=1 → on=0, cleaning=0, evading=0 asynchronously. Release with raw_on_btn held at 1 → on never pulses within 50 cycles.
- Button: raw_on_btn 0→1, held 10 cycles → on high for exactly 1 cycle, 7 cycles after the raw edge. Second press after a 10-cycle release → second single pulse.
- Glitch reject: raw_bumper high for 3 cycles, then low → evading stays 0. High for 5 cycles → evading rises 7 cycles after the raw edge.
- Dirt hold: raw_dirt high for 20 cycles, then low → cleaning rises 7 cycles after the raw edge and stays high for exactly 36 consecutive cycles.
- Retrigger: raw_bumper high 10, low 4, high 10, low → evading stays continuously high from first rise until 8 cycles after the second debounced fall.
- Priority: with ASPIRADORA_BUMPER_PRIORITY_EN defined, raw_dirt and raw_bumper high together for 12 cycles → evading=1, cleaning=0 throughout. Without the macro → both =1.
